uart_tx_mmio: RTL and testbench
===============================

# uart_tx_mmio

Memory-mapped UART transmitter sitting on the CPU data bus next to program memory; it consumes the same address, write-data, write-strobe and read-strobe signals the CPU drives. Bytes written to its data register enter a small FIFO and are serialised 8N1 on `tx`. A status register is readable over the same bus. The top-level address decoder uses `sel` to mux its `mem_rdata` against program memory.

## Interface
- `BASE_ADDR`, 32'h0040_0000: word-aligned base; TXDATA at +0, STATUS at +4.
- `CLKS_PER_BIT`, 868: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, 8: FIFO entries; power of two, ≥2.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_addr`  in  32: CPU byte address.
- `mem_wdata`  in  32: CPU write data.
- `mem_wstrb`  in  4: byte-lane write strobes; any bit set means write.
- `mem_rstrb`  in  1: CPU read strobe.
- `mem_rdata`  out  32: registered read data.
- `sel`  out  1: combinational; 1 when `mem_addr[31:3] == BASE_ADDR[31:3]`.
- `tx`  out  1: serial output, idle high.
- `busy`  out  1: 1 when FSM not IDLE or FIFO non-empty.

## Operation
- Write to TXDATA with `sel` and `mem_wstrb[0]`:
  - FIFO not full: push `mem_wdata[7:0]`.
  - FIFO full: drop the byte and set sticky `ovf`.
  - Full is evaluated on the pre-edge state, so a same-cycle pop does not admit the push.
- Write to STATUS with `mem_wstrb[0]` and `mem_wdata[3]`=1: clear `ovf`. Other bits are read-only.
- Writes with `mem_wstrb[0]`=0 have no effect.
- STATUS read value:
  - bit0 = full
  - bit1 = empty
  - bit2 = FSM not IDLE
  - bit3 = `ovf`
  - bits[7+log2(FIFO_DEPTH):8] = FIFO count
  - all other bits 0
- TXDATA read returns 0.
- Read: `sel` and `mem_rstrb` at edge E load `mem_rdata` at E. Otherwise `mem_rdata` holds its value.
- FSM states: IDLE, START, DATA, [PARITY], STOP.
  - IDLE: `tx`=1. If FIFO non-empty: pop into shift register, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; 3-bit index, shifts right.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On the last cycle, if FIFO non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter: loads CLKS_PER_BIT-1 on state or bit entry and decrements to 0. The bit ends on the cycle the counter is 0.
- FIFO: circular read/write pointers plus count of width log2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH. Simultaneous push (not full) and pop: count unchanged.

## Timing
- Reset (async assert): `tx`=1, `busy`=0, `mem_rdata`=0, FIFO empty, `ovf`=0, FSM IDLE, counters 0. Reset mid-frame aborts it; `tx` goes high immediately.
- Write at edge E0 into an empty FIFO with FSM IDLE:
  - `busy`=1 after E0.
  - Pop at E1; `tx`=0 after E1.
  - Start bit spans E1..E1+CLKS_PER_BIT.
- Frame length: 10·CLKS_PER_BIT cycles (11 with parity). `busy` falls one cycle after the final STOP cycle when the FIFO is empty.
- Read latency: 1 cycle (data valid after the strobe edge).

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted between DATA and STOP; `tx` = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - STATUS bit4 reads 1.
- Undefined: no PARITY state, 8N1 frame, STATUS bit4 = 0.

## Test plan
- Reset then idle: `rst`=0 mid-simulation → `tx`=1, `busy`=0, `mem_rdata`=0. Read STATUS → 32'h0000_0002.
- Single byte, CLKS_PER_BIT=4: write 8'hA5 to TXDATA → `tx` after pop edge is 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. `busy` falls after 40 cycles plus 1.
- Back-to-back: write 8'h00 then 8'hFF on consecutive cycles → second start bit immediately follows the first stop bit, no idle cycle. Total 80 cycles.
- Overflow, FIFO_DEPTH=8: 10 writes while the FSM holds byte 0 → bytes 0..8 are transmitted, byte 9 is dropped, STATUS bit3=1. Write 32'h8 to STATUS → bit3=0.
- Reset mid-frame: drop `rst` during DATA bit 3 → `tx`=1 asynchronously. After release, STATUS = 32'h2 and no residual bits are emitted.
- Parity (macro defined): write 8'h07 → parity bit 1, frame of 11 bits. Write 8'h03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with a byte FIFO and a STATUS register.
// Define UART_TX_PARITY_EN to insert an even-parity bit between DATA and STOP.
module uart_tx_mmio #(
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000,
    parameter int          CLKS_PER_BIT = 868,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        sel,
    output logic        tx,
    output logic        busy
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BIT_LOAD = BW'(CLKS_PER_BIT - 1);
`ifdef UART_TX_PARITY_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t        state_q, state_d;
    logic [BW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   status;
    logic [7:0]    head;
    logic          full, empty, push, pop, wr_data, wr_status, bit_end;
    logic          unused_bits;
    assign sel       = mem_addr[31:3] == BASE_ADDR[31:3];
    assign wr_data   = sel & mem_wstrb[0] & ~mem_addr[2];
    assign wr_status = sel & mem_wstrb[0] & mem_addr[2];
    assign full      = count_q == (AW+1)'(FIFO_DEPTH);
    assign empty     = count_q == '0;
    assign push      = wr_data & ~full;
    assign head      = fifo_q[rd_ptr_q];
    assign bit_end   = cnt_q == '0;
    assign count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
    assign ovf_d     = (wr_data & full) ? 1'b1 : (wr_status & mem_wdata[3]) ? 1'b0 : ovf_q;
    assign status    = (32'(count_q[AW-1:0]) << 8)
                     | {27'b0, PAR_EN, ovf_q, state_q != IDLE, empty, full};
    assign rdata_d   = (sel & mem_rstrb) ? (mem_addr[2] ? status : '0) : rdata_q;
    assign mem_rdata = rdata_q;
    assign busy      = (state_q != IDLE) | ~empty;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8], mem_wstrb[3:1]};
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? cnt_q : cnt_q - BW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = START;
                cnt_d   = BIT_LOAD;
            end
            START: if (bit_end) begin
                state_d = DATA;
                cnt_d   = BIT_LOAD;
                bit_d   = 3'd0;
            end
            DATA: if (bit_end) begin
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                cnt_d   = BIT_LOAD;
`ifdef UART_TX_PARITY_EN
                if (bit_q == 3'd7) state_d = PARITY;
`else
                if (bit_q == 3'd7) state_d = STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) begin
                state_d = STOP;
                cnt_d   = BIT_LOAD;
            end
`endif
            STOP: if (bit_end) begin
                // a queued byte chains straight into the next start bit
                pop     = ~empty;
                state_d = empty ? IDLE : START;
                cnt_d   = empty ? cnt_q : BIT_LOAD;
            end
            default: state_d = IDLE;
        endcase
        if (pop) shift_d = head;
    end
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= mem_wdata[7:0];
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end
`ifdef UART_TX_PARITY_EN
    logic par_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) par_q <= 1'b0;
        else if (pop) par_q <= ^head;
    end
    assign tx = state_q == START  ? 1'b0 :
                state_q == DATA   ? shift_q[0] :
                state_q == PARITY ? par_q : 1'b1;
`else
    assign tx = state_q == START ? 1'b0 : state_q == DATA ? shift_q[0] : 1'b1;
`endif
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed bench for uart_tx_mmio with CLKS_PER_BIT=4, FIFO_DEPTH=8.
module tb_uart_tx_mmio;
    localparam logic [31:0] BASE = 32'h0040_0000;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] STS  = BASE + 32'd4;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    localparam logic [31:0] PB = 32'h10;
    localparam bit PAR = 1'b1;
`else
    localparam int NBITS = 10;
    localparam logic [31:0] PB = 32'h0;
    localparam bit PAR = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rstrb, sel, tx, busy;
    int vectors = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_tx_mmio #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
        .sel(sel), .tx(tx), .busy(busy)
    );

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        mem_addr = a; mem_wdata = d; mem_wstrb = 4'h1;
        @(negedge clk);
        mem_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        mem_addr = a; mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        d = mem_rdata;
    endtask

    // Starts on the first negedge of the start bit, ends one negedge past the last stop cycle.
    task automatic check_frame(input logic [7:0] b, input logic p, input string name);
        logic [10:0] bits;
        bits = {1'b1, PAR ? p : 1'b1, b, 1'b0};
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < CPB; c++) begin
                vectors++;
                if (tx !== bits[k] || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s bit%0d cyc%0d: tx=%b busy=%b, expected tx=%b busy=1", name, k, c, tx, busy, bits[k]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic rx_byte(output logic [7:0] b, output logic ok);
        ok = 1'b0; b = '0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (tx === 1'b0) ok = 1'b1;
        end
        if (ok) begin
            repeat (CPB + 1) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                b[k] = tx;
                if (k < 7) repeat (CPB) @(negedge clk);
            end
            repeat (CPB * (NBITS - 9)) @(negedge clk);
            if (tx !== 1'b1) ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        logic [31:0] d;
        bus_read(STS, d);
        vectors++;
        if (d !== (32'h2 | PB)) begin errors++; $display("FAIL reset_pre_status: got %h expected %h", d, 32'h2 | PB); end
        #2 rst = 1'b0;
        #1 vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || mem_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: tx=%b busy=%b rdata=%h expected 1 0 0", tx, busy, mem_rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        bus_read(STS, d);
        vectors++;
        if (d !== (32'h2 | PB)) begin errors++; $display("FAIL reset_status: got %h expected %h", d, 32'h2 | PB); end
    endtask

    task automatic test_decode;
        logic [31:0] d;
        logic [31:0] addrs [4] = '{BASE + 32'd8, BASE - 32'd4, BASE + 32'd7, BASE};
        logic        sels  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            mem_addr = addrs[i];
            #1 vectors++;
            if (sel !== sels[i]) begin errors++; $display("FAIL sel_%0d: addr=%h sel=%b expected %b", i, addrs[i], sel, sels[i]); end
        end
        bus_write(BASE + 32'd8, 32'h55);
        @(negedge clk);
        mem_addr = TXD; mem_wdata = 32'h55; mem_wstrb = 4'hE;
        @(negedge clk);
        mem_wstrb = 4'h0;
        repeat (3) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL ignored_writes: busy=%b tx=%b expected 0 1", busy, tx); end
        bus_read(STS, d);
        mem_addr = TXD;
        repeat (3) @(negedge clk);
        vectors++;
        if (mem_rdata !== (32'h2 | PB)) begin errors++; $display("FAIL rdata_hold: got %h expected %h", mem_rdata, 32'h2 | PB); end
        bus_read(TXD, d);
        vectors++;
        if (d !== 32'h0) begin errors++; $display("FAIL txdata_read: got %h expected 0", d); end
    endtask

    task automatic test_single;
        bus_write(TXD, 32'hA5);
        vectors++;
        if (busy !== 1'b1 || tx !== 1'b1) begin errors++; $display("FAIL single_accept: busy=%b tx=%b expected 1 1", busy, tx); end
        @(negedge clk);
        check_frame(8'hA5, 1'b0, "single_a5");
        vectors++;
        if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_done: busy=%b tx=%b expected 0 1", busy, tx); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        mem_addr = TXD; mem_wdata = 32'h00; mem_wstrb = 4'h1;
        @(negedge clk);
        mem_wdata = 32'hFF;
        @(negedge clk);
        mem_wstrb = 4'h0;
        check_frame(8'h00, 1'b0, "b2b_first");
        check_frame(8'hFF, 1'b0, "b2b_second");
        vectors++;
        if (busy !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL b2b_done: busy=%b tx=%b expected 0 1", busy, tx); end
    endtask

    task automatic test_overflow;
        logic [31:0] d;
        logic [7:0]  b;
        logic        ok, stuck;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    mem_addr = TXD; mem_wdata = 32'(8'h41 + i); mem_wstrb = 4'h1;
                end
                @(negedge clk);
                mem_wstrb = 4'h0; mem_addr = STS; mem_rstrb = 1'b1;
                @(negedge clk);
                mem_rstrb = 1'b0;
                vectors++;
                if (mem_rdata !== (32'hD | PB)) begin errors++; $display("FAIL ovf_status_full: got %h expected %h", mem_rdata, 32'hD | PB); end
                repeat (35) @(negedge clk);
                bus_read(STS, d);
                vectors++;
                if (d !== (32'h70C | PB)) begin errors++; $display("FAIL ovf_status_count7: got %h expected %h", d, 32'h70C | PB); end
            end
            begin
                for (int i = 0; i < 9; i++) begin
                    rx_byte(b, ok);
                    vectors++;
                    if (!ok || b !== 8'(8'h41 + i)) begin
                        errors++;
                        $display("FAIL ovf_rx_%0d: got %h ok=%b expected %h", i, b, ok, 8'(8'h41 + i));
                    end
                end
            end
        join
        stuck = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) stuck = 1'b1;
        end
        vectors++;
        if (stuck || busy !== 1'b0) begin errors++; $display("FAIL ovf_dropped: extra tx activity=%b busy=%b expected 0 0", stuck, busy); end
        bus_read(STS, d);
        vectors++;
        if (d !== (32'hA | PB)) begin errors++; $display("FAIL ovf_sticky: got %h expected %h", d, 32'hA | PB); end
        bus_write(STS, 32'h8);
        bus_read(STS, d);
        vectors++;
        if (d !== (32'h2 | PB)) begin errors++; $display("FAIL ovf_clear: got %h expected %h", d, 32'h2 | PB); end
    endtask

    task automatic test_reset_midframe;
        logic [31:0] d;
        logic        stuck;
        bus_write(TXD, 32'h00);
        repeat (18) @(negedge clk);
        vectors++;
        if (tx !== 1'b0) begin errors++; $display("FAIL midframe_bit3: tx=%b expected 0", tx); end
        #2 rst = 1'b0;
        #1 vectors++;
        if (tx !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL midframe_async: tx=%b busy=%b expected 1 0", tx, busy); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        stuck = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (tx !== 1'b1) stuck = 1'b1;
        end
        vectors++;
        if (stuck) begin errors++; $display("FAIL midframe_residual: tx left idle after reset, expected steady 1"); end
        bus_read(STS, d);
        vectors++;
        if (d !== (32'h2 | PB)) begin errors++; $display("FAIL midframe_status: got %h expected %h", d, 32'h2 | PB); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity;
        bus_write(TXD, 32'h07);
        @(negedge clk);
        check_frame(8'h07, 1'b1, "parity_07");
        bus_write(TXD, 32'h03);
        @(negedge clk);
        check_frame(8'h03, 1'b0, "parity_03");
        vectors++;
        if (busy !== 1'b0) begin errors++; $display("FAIL parity_done: busy=%b expected 0", busy); end
    endtask
`endif

    initial begin
        rst = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0; mem_rstrb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        test_reset;
        test_decode;
        test_single;
        test_back_to_back;
        test_overflow;
        test_reset_midframe;
`ifdef UART_TX_PARITY_EN
        test_parity;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
